axi3_wr_arbiter: RTL
====================

Name: axi3_wr_arbiter

Overview:
- Shares the single AXI3 write port to the bus between two AXI3 write masters: the d$ write buffer (port 0) and the uncached store path (port 1).
- Grants one complete burst at a time: the grant covers the AW, W and B phases, with at most 1 outstanding transaction.
- Default policy is round-robin. Forwarding is combinational; grant decisions are registered.
- Sits between the cache write-side logic and the top-level AXI3 crossbar.

Parameters:
- BURST_MAX, 8: maximum beats per burst (awlen+1). Sizes the beat counter: $clog2(BURST_MAX)+1 bits.
- ERR_CHECK, 1: enables the wlast/awlen consistency checker (1 = on).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- s0_wr_if  axi3_wr_if.slave  iface  requester 0 (d$ write buffer)
- s1_wr_if  axi3_wr_if.slave  iface  requester 1 (uncached store)
- m_wr_if  axi3_wr_if.master  iface  shared bus port
- grant  output  2  one-hot current owner; 2'b00 when idle
- busy  output  1  state != ARB_IDLE
- proto_err  output  1  sticky: a granted burst's wlast disagreed with its awlen

Behaviour:
- Reset: asynchronous on rst_n low. Required values:
  - state=ARB_IDLE, grant=0, busy=0, proto_err=0, last_owner=1 (so port 0 wins first).
  - All master awvalid/wvalid/bready = 0; all slave awready/wready/bvalid = 0.
  - Reset mid-burst abandons the transaction silently.
- States: ARB_IDLE -> ARB_AW -> ARB_W -> ARB_B -> ARB_IDLE.
- ARB_IDLE:
  - Sample s0/s1 awvalid. If exactly one is set, that port wins. If both are set, the port != last_owner wins.
  - On a win, register owner and go to ARB_AW next cycle: 1-cycle arbitration latency, and the master awvalid is first asserted the cycle after the slave awvalid.
  - No request: stay in ARB_IDLE.
- ARB_AW:
  - Forward the owner's AW fields and awvalid to the master unchanged; drive master awid = owner's awid.
  - Return awready to the owner only.
  - On master awvalid&&awready: latch awlen, clear beat_cnt, go to ARB_W.
- ARB_W:
  - Forward owner wdata/wstrb/wlast/wvalid and wid; return wready to the owner only.
  - Each wvalid&&wready increments beat_cnt.
  - The beat with wlast=1 accepted moves to ARB_B.
  - If ERR_CHECK: set proto_err when (wlast accepted && beat_cnt != awlen), or when beat_cnt == awlen accepted without wlast. The state still follows wlast only.
- ARB_B:
  - Forward master bvalid/bresp to the owner and owner bready to the master.
  - On bvalid&&bready: last_owner=owner, go to ARB_IDLE.
  - A request waiting at that edge is arbitrated in the following ARB_IDLE cycle, so the minimum gap between bursts is 1 idle cycle.
- Non-owner port: awready=wready=bvalid=0 at all times. Its signals never reach the master.
- An AW raised by a slave while the arbiter is busy is held pending by that slave under the AXI valid-stays-high rule; no requests are dropped.
- A W beat before AW acceptance is not supported: W is forwarded only in ARB_W.
- grant = one-hot owner in every state except ARB_IDLE.
- beat_cnt saturates at BURST_MAX and never wraps.

Optional Feature:
- WR_ARB_FIXED_PRIO_EN defined: fixed priority, port 1 (uncached) always wins a simultaneous request; last_owner is unused.
- Not defined: round-robin as described above.

Test Plan:
- Single port 0 burst, awlen=7, slave always ready -> master awvalid at cycle 1, 8 beats in ARB_W, bvalid returned to s0; grant=01 throughout; s1 sees no ready; busy drops after B.
- s0 and s1 awvalid together from reset -> s0 is served first (grant=01); after its B, s1 is served (grant=10) after exactly 1 idle cycle. With WR_ARB_FIXED_PRIO_EN, s1 is served first.
- Master wready toggles 1,0,1,0 during an 8-beat burst -> all 8 beats are forwarded in order, wlast appears on beat 7, proto_err=0.
- s1 bursts with awlen=3 but wlast on the 2nd beat -> proto_err=1 and stays 1; the arbiter still reaches ARB_B and completes.
- rst_n pulsed low during ARB_W, beat 4 -> same-cycle async clear: grant=0, master wvalid=0, state=ARB_IDLE; a new s0 request after rst_n rises is served normally.
- Back-to-back s0 requests while s1 is idle -> s0 is granted repeatedly with a 1-cycle IDLE gap between bursts.

Source files
------------

// File: rtl/axi3_wr_arbiter_if.sv
// ============================================================================
// Module   : axi3_wr_if
// Brief    : AXI3 write-channel bundle (AW, W, B) shared by the write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi3_wr_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

`default_nettype wire

// File: rtl/axi3_wr_arbiter.sv
// ============================================================================
// Module   : axi3_wr_arbiter
// Brief    : Two-port AXI3 write arbiter, one whole burst (AW/W/B) at a time.
//            Define WR_ARB_FIXED_PRIO_EN for fixed priority (port 1 wins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi3_wr_arbiter #(
    parameter int BURST_MAX = 8,
    parameter bit ERR_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    axi3_wr_if.slave   s0_wr_if,
    axi3_wr_if.slave   s1_wr_if,
    axi3_wr_if.master  m_wr_if,
    output logic [1:0] grant,
    output logic       busy,
    output logic       proto_err
);

    localparam int                 c_CNT_W   = $clog2(BURST_MAX) + 1;
    localparam logic [c_CNT_W-1:0] c_BEAT_SAT = c_CNT_W'(BURST_MAX);

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_AW   = 2'd1;
    localparam logic [1:0] ARB_W    = 2'd2;
    localparam logic [1:0] ARB_B    = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_owner;
    logic [3:0]         r_awlen;
    logic [c_CNT_W-1:0] r_beat_cnt;
    logic [1:0]         w_req;
    logic               w_winner;
    logic               w_own_wlast;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_b_hs;

    assign w_req       = {s1_wr_if.awvalid, s0_wr_if.awvalid};
    assign w_own_wlast = r_owner ? s1_wr_if.wlast : s0_wr_if.wlast;
    assign w_aw_hs     = (r_state == ARB_AW) && m_wr_if.awvalid && m_wr_if.awready;
    assign w_w_hs      = (r_state == ARB_W)  && m_wr_if.wvalid  && m_wr_if.wready;
    assign w_b_hs      = (r_state == ARB_B)  && m_wr_if.bvalid  && m_wr_if.bready;

`ifdef WR_ARB_FIXED_PRIO_EN
    assign w_winner = w_req[1];
`else
    logic r_last_owner;

    // With both requesting, the port that did not own the previous burst wins.
    assign w_winner = (w_req == 2'b11) ? ~r_last_owner : w_req[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_owner <= 1'b1;
        end else if (w_b_hs) begin
            r_last_owner <= r_owner;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_owner    <= 1'b0;
            r_awlen    <= 4'd0;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ARB_IDLE) && (|w_req)) begin
                r_owner <= w_winner;
            end
            if (w_aw_hs) begin
                r_awlen    <= m_wr_if.awlen;
                r_beat_cnt <= '0;
            end else if (w_w_hs && (r_beat_cnt != c_BEAT_SAT)) begin
                r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (|w_req)                  w_state_nxt = ARB_AW;
            ARB_AW:   if (w_aw_hs)                 w_state_nxt = ARB_W;
            ARB_W:    if (w_w_hs && w_own_wlast)   w_state_nxt = ARB_B;
            ARB_B:    if (w_b_hs)                  w_state_nxt = ARB_IDLE;
            default:                               w_state_nxt = ARB_IDLE;
        endcase
    end

    // Payload follows the owner; only the handshake signals are phase-gated.
    always_comb begin
        m_wr_if.awid    = r_owner ? s1_wr_if.awid    : s0_wr_if.awid;
        m_wr_if.awaddr  = r_owner ? s1_wr_if.awaddr  : s0_wr_if.awaddr;
        m_wr_if.awlen   = r_owner ? s1_wr_if.awlen   : s0_wr_if.awlen;
        m_wr_if.awsize  = r_owner ? s1_wr_if.awsize  : s0_wr_if.awsize;
        m_wr_if.awburst = r_owner ? s1_wr_if.awburst : s0_wr_if.awburst;
        m_wr_if.awlock  = r_owner ? s1_wr_if.awlock  : s0_wr_if.awlock;
        m_wr_if.awcache = r_owner ? s1_wr_if.awcache : s0_wr_if.awcache;
        m_wr_if.awprot  = r_owner ? s1_wr_if.awprot  : s0_wr_if.awprot;
        m_wr_if.wid     = r_owner ? s1_wr_if.wid     : s0_wr_if.wid;
        m_wr_if.wdata   = r_owner ? s1_wr_if.wdata   : s0_wr_if.wdata;
        m_wr_if.wstrb   = r_owner ? s1_wr_if.wstrb   : s0_wr_if.wstrb;
        m_wr_if.wlast   = w_own_wlast;
        m_wr_if.awvalid = 1'b0;
        m_wr_if.wvalid  = 1'b0;
        m_wr_if.bready  = 1'b0;
        s0_wr_if.awready = 1'b0;
        s0_wr_if.wready  = 1'b0;
        s0_wr_if.bvalid  = 1'b0;
        s0_wr_if.bid     = m_wr_if.bid;
        s0_wr_if.bresp   = m_wr_if.bresp;
        s1_wr_if.awready = 1'b0;
        s1_wr_if.wready  = 1'b0;
        s1_wr_if.bvalid  = 1'b0;
        s1_wr_if.bid     = m_wr_if.bid;
        s1_wr_if.bresp   = m_wr_if.bresp;
        case (r_state)
            ARB_AW: begin
                m_wr_if.awvalid = r_owner ? s1_wr_if.awvalid : s0_wr_if.awvalid;
                if (r_owner) s1_wr_if.awready = m_wr_if.awready;
                else         s0_wr_if.awready = m_wr_if.awready;
            end
            ARB_W: begin
                m_wr_if.wvalid = r_owner ? s1_wr_if.wvalid : s0_wr_if.wvalid;
                if (r_owner) s1_wr_if.wready = m_wr_if.wready;
                else         s0_wr_if.wready = m_wr_if.wready;
            end
            ARB_B: begin
                m_wr_if.bready = r_owner ? s1_wr_if.bready : s0_wr_if.bready;
                if (r_owner) s1_wr_if.bvalid = m_wr_if.bvalid;
                else         s0_wr_if.bvalid = m_wr_if.bvalid;
            end
            default: ;
        endcase
    end

    assign busy  = (r_state != ARB_IDLE);
    assign grant = busy ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

    generate
        if (ERR_CHECK) begin : g_err_chk
            logic r_proto_err;
            // r_beat_cnt holds the zero-based index of the beat being accepted.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_proto_err <= 1'b0;
                end else if (w_w_hs &&
                             (( w_own_wlast && (32'(r_beat_cnt) != 32'(r_awlen))) ||
                              (!w_own_wlast && (32'(r_beat_cnt) == 32'(r_awlen))))) begin
                    r_proto_err <= 1'b1;
                end
            end
            assign proto_err = r_proto_err;
        end else begin : g_no_err_chk
            assign proto_err = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire
